// File: rtl/conv_layer_input_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_layer_input_ctrl_pkg                                            |
// | Shared cmd/ack codes, image geometry and controller state encoding.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package conv_layer_input_ctrl_pkg;

  localparam int IMAGE_SIZE  = 8;
  localparam int KERNEL_SIZE = 3;

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  localparam logic [1:0] ACK_IDLE        = 2'd0;
  localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
  localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PRE_REQ  = 4'd1,
    ST_PRE_WAIT = 4'd2,
    ST_SHF_REQ  = 4'd3,
    ST_SHF_WAIT = 4'd4,
    ST_LD_REQ   = 4'd5,
    ST_LD_WAIT  = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERROR    = 4'd8
  } ctrl_state_t;

  // In a WAIT state: a foreign nonzero ack, or silence until the watchdog fires.
  function automatic logic ack_fault(input logic [1:0] ack,
                                     input logic [1:0] expected,
                                     input logic       expire);
    return ((ack != ACK_IDLE) && (ack != expected)) ||
           ((ack == ACK_IDLE) && expire);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_layer_input_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_layer_input_ctrl_if                                             |
// | Command/ack bus between the sequencer and the conv input interface.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface conv_layer_input_ctrl_if;

  logic [1:0] o_cmd;
  logic       o_if_enable;
  logic [1:0] i_ack;

  modport master (
    output o_cmd,
    output o_if_enable,
    input  i_ack
  );

  modport slave (
    input  o_cmd,
    input  o_if_enable,
    output i_ack
  );

endinterface
`default_nettype wire

// File: rtl/conv_layer_input_ctrl_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_ack_watchdog                                                    |
// | Counts cycles spent waiting for an ack; expire at TIMEOUT-1.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv_ack_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_W-1:0] cnt;

  assign expire = (cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_layer_input_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_layer_input_ctrl                                                |
// | Sequences PRELOAD/SHIFT/LOAD commands to walk one image through the  |
// | convolution window, reporting rows, done and errors.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conv_layer_input_ctrl #(
  parameter int IMAGE_SIZE  = conv_layer_input_ctrl_pkg::IMAGE_SIZE,
  parameter int KERNEL_SIZE = conv_layer_input_ctrl_pkg::KERNEL_SIZE,
  parameter int OUT_ROWS    = IMAGE_SIZE - KERNEL_SIZE + 1,
  parameter int ROW_W       = 3,
  parameter int TIMEOUT     = 64,
  parameter int TO_W        = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_hold,
  conv_layer_input_ctrl_if.master bus,
  output logic                    o_busy,
  output logic                    o_row_valid,
  output logic [ROW_W-1:0]        o_row_idx,
  output logic                    o_done,
  output logic                    o_err
);

  import conv_layer_input_ctrl_pkg::*;

  ctrl_state_t      state;
  logic [ROW_W-1:0] row;
  logic [1:0]       ack;
  logic             in_wait;
  logic             wd_clear;
  logic             wd_expire;
  logic [1:0]       cmd;
  logic             active;

  assign ack = bus.i_ack;

  always_comb begin
    in_wait  = (state == ST_PRE_WAIT) || (state == ST_SHF_WAIT) ||
               (state == ST_LD_WAIT);
    wd_clear = !in_wait;
  end

  conv_ack_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (in_wait),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      row         <= '0;
      o_row_valid <= 1'b0;
      o_row_idx   <= '0;
    end else begin
      o_row_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (i_start) begin
            state <= ST_PRE_REQ;
            row   <= '0;
          end
        end
        ST_PRE_REQ: state <= ST_PRE_WAIT;
        ST_PRE_WAIT: begin
          if (ack == ACK_PRELOAD_FIN) begin
            state <= ST_SHF_REQ;
          end else if (ack_fault(ack, ACK_PRELOAD_FIN, wd_expire)) begin
            state <= ST_ERROR;
          end
        end
        // SHIFT is issued only in a cycle with no downstream hold.
        ST_SHF_REQ: begin
          if (!i_hold) begin
            state <= ST_SHF_WAIT;
          end
        end
        ST_SHF_WAIT: begin
          if (ack == ACK_SHIFT_FIN) begin
            o_row_valid <= 1'b1;
            o_row_idx   <= row;
            row         <= row + ROW_W'(1);
            state       <= (row == ROW_W'(OUT_ROWS - 1)) ? ST_DONE : ST_LD_REQ;
          end else if (ack_fault(ack, ACK_SHIFT_FIN, wd_expire)) begin
            state <= ST_ERROR;
          end
        end
        ST_LD_REQ: state <= ST_LD_WAIT;
        ST_LD_WAIT: begin
          if (ack == ACK_LOAD_FIN) begin
            state <= ST_SHF_REQ;
          end else if (ack_fault(ack, ACK_LOAD_FIN, wd_expire)) begin
            state <= ST_ERROR;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd = CMD_IDLE;
    case (state)
      ST_PRE_REQ: cmd = CMD_PRELOAD;
      ST_SHF_REQ: cmd = i_hold ? CMD_IDLE : CMD_SHIFT;
      ST_LD_REQ:  cmd = CMD_LOAD;
      default:    cmd = CMD_IDLE;
    endcase
  end

  assign active          = (state != ST_IDLE) && (state != ST_DONE) &&
                           (state != ST_ERROR);
  assign bus.o_cmd       = cmd;
  assign bus.o_if_enable = active;
  assign o_busy          = active;
  assign o_done          = (state == ST_DONE);
  assign o_err           = (state == ST_ERROR);

endmodule
`default_nettype wire
